// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared types and sizing helpers for the chunked adder sequencer
//   Contents: sequencer state enum, chunk-count and chunk-index-width helpers.
package add_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} add_seq_state_t;

   // Number of CHUNK-wide slices needed to cover WIDTH bits.
   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Width of the chunk index; at least one bit so a single-chunk build still has a counter.
   function automatic int idx_width(input int width, input int chunk);
      int n;
      n = nchunk(width, chunk);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational CHUNK-bit ripple-carry adder slice
//   a, b : CHUNK-bit addends     ci : carry in
//   s    : CHUNK-bit sum         co : carry out of the top bit
module add_slice #(
   parameter int CHUNK = 3
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic [CHUNK:0] c;

   // Chain of full adders, bit 0 first.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[CHUNK];
   end

endmodule

// File: rtl/chunked_add_seq.sv
// rtl/chunked_add_seq.sv - multi-cycle adder reusing one CHUNK-bit slice, LSB chunk first
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, b, cin)
//   out_valid/out_ready  : result handshake (sum, cout)
//   sum, cout            : (a + b + cin) mod 2^WIDTH and the carry out of bit WIDTH-1
module chunked_add_seq
   import add_seq_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int CHUNK = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IDX_W  = idx_width(WIDTH, CHUNK);

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunked_add_seq: WIDTH must be a positive multiple of CHUNK");
   end

   add_seq_state_t    state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              carry_q;
   // work_q collects partial sums during RUN so sum_q keeps the previous
   // result visible until the new one is complete.
   logic [WIDTH-1:0]  work_q;
   logic [WIDTH-1:0]  work_d;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q;

   logic [CHUNK-1:0]  slice_a;
   logic [CHUNK-1:0]  slice_b;
   logic [CHUNK-1:0]  slice_s;
   logic              slice_co;
   logic              last_chunk;

   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == IDX_W'(i)) begin
            slice_a = a_q[i*CHUNK +: CHUNK];
            slice_b = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   add_slice #(.CHUNK(CHUNK)) u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   always_comb begin
      work_d = work_q;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == IDX_W'(i)) begin
            work_d[i*CHUNK +: CHUNK] = slice_s;
         end
      end
   end

   assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               work_q  <= work_d;
               carry_q <= slice_co;
               if (last_chunk) begin
                  sum_q   <= work_d;
                  cout_q  <= slice_co;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_add_seq.sv
// tb/tb_chunked_add_seq.sv - self-checking bench for chunked_add_seq
module tb_chunked_add_seq;

   localparam int WIDTH  = 12;
   localparam int CHUNK  = 3;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   chunked_add_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Reference: plain integer addition, carry is bit WIDTH.
   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operand set, waits for the result; out_ready is left as the caller set it.
   // lat counts edges from acceptance to the first cycle with out_valid.
   task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                         output logic [WIDTH-1:0] s, output logic co, output int lat,
                         output int acc_cycle, output bit timeout);
      int w;
      w = 0;
      timeout = 1'b0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      in_valid = 1'b1;
      a = av;
      b = bv;
      cin = cv;
      acc_cycle = cycle;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      timeout = !out_valid;
      s = sum;
      co = cout;
      if (out_ready) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      cin = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (sum !== 12'h000) begin n_fail++; $display("FAIL reset_sum got %h want 000", sum); end
      n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] ta [5] = '{12'h7FF, 12'hFFF, 12'hFFF, 12'h000, 12'h555};
      logic [WIDTH-1:0] tb [5] = '{12'h001, 12'h001, 12'hFFF, 12'h000, 12'hAAA};
      logic             tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [WIDTH-1:0] es [5] = '{12'h800, 12'h000, 12'hFFF, 12'h000, 12'h000};
      logic             ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [WIDTH-1:0] s;
      logic co;
      int lat, acc;
      bit to;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_op(ta[i], tb[i], tc[i], s, co, lat, acc, to);
         n_checks++; if (to) begin n_fail++; $display("FAIL directed_timeout case %0d no out_valid", i); end
         n_checks++; if (lat !== NCHUNK) begin n_fail++; $display("FAIL directed_latency case %0d got %0d want %0d", i, lat, NCHUNK); end
         n_checks++; if (s !== es[i]) begin n_fail++; $display("FAIL directed_sum case %0d got %h want %h", i, s, es[i]); end
         n_checks++; if (co !== ec[i]) begin n_fail++; $display("FAIL directed_cout case %0d got %b want %b", i, co, ec[i]); end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL directed_idle case %0d in_ready got %b want 1", i, in_ready); end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] prev_sum;
      prev_sum = sum;
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 12'h123;
      b = 12'h456;
      cin = 1'b0;
      tick();
      // Keep requesting with different operands through RUN and DONE.
      for (int k = 0; k < NCHUNK + 6; k++) begin
         in_valid = k[0];
         a = 12'hFFF;
         b = 12'hFFF;
         cin = 1'b1;
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, in_ready); end
         if (k < NCHUNK - 1) begin
            n_checks++; if (sum !== prev_sum) begin n_fail++; $display("FAIL bp_sum_prev cycle %0d got %h want %h", k, sum, prev_sum); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_early_valid cycle %0d got %b want 0", k, out_valid); end
         end else if (k >= NCHUNK) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held cycle %0d got %b want 1", k, out_valid); end
            n_checks++; if (sum !== 12'h579 || cout !== 1'b0) begin n_fail++; $display("FAIL bp_sum_held cycle %0d got %h/%b want 579/0", k, sum, cout); end
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid); end
      n_checks++; if (sum !== 12'h579) begin n_fail++; $display("FAIL bp_sum_kept got %h want 579", sum); end
      tick();
      tick();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_phantom_op in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid_run();
      logic [WIDTH-1:0] s;
      logic co;
      int lat, acc;
      bit to;
      bit seen;
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = 12'hABC;
      b = 12'h321;
      cin = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      // idx is now 2; reset takes effect at the next edge.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++; if (sum !== 12'h000 || cout !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state got sum=%h cout=%b ready=%b want 000/0/1", sum, cout, in_ready); end
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_aborted out_valid seen=%b want 0", seen); end
      run_op(12'h00A, 12'h005, 1'b0, s, co, lat, acc, to);
      n_checks++; if (to || s !== 12'h00F || co !== 1'b0) begin n_fail++; $display("FAIL midrst_next got %h/%b timeout=%b want 00f/0", s, co, to); end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] av, bv, s;
      logic cv, co;
      logic [WIDTH:0] exp_v;
      int lat, acc, hold;
      bit to;
      for (int i = 0; i < 40; i++) begin
         av = WIDTH'($urandom);
         bv = WIDTH'($urandom);
         cv = 1'($urandom);
         exp_v = ref_add(av, bv, cv);
         out_ready = 1'b0;
         run_op(av, bv, cv, s, co, lat, acc, to);
         hold = $urandom_range(0, 3);
         for (int k = 0; k < hold; k++) tick();
         n_checks++; if (to || lat !== NCHUNK) begin n_fail++; $display("FAIL rand_latency op %0d got %0d want %0d", i, lat, NCHUNK); end
         n_checks++; if ({co, s} !== exp_v || {cout, sum} !== exp_v) begin n_fail++; $display("FAIL rand_result op %0d %h+%h+%b got %b/%h want %h", i, av, bv, cv, cout, sum, exp_v); end
         out_ready = 1'b1;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] av, bv, s;
      logic cv, co;
      logic [WIDTH:0] exp_v;
      int lat, acc, prev_acc;
      bit to;
      out_ready = 1'b1;
      prev_acc = -1;
      for (int i = 0; i < 6; i++) begin
         av = WIDTH'($urandom);
         bv = WIDTH'($urandom);
         cv = 1'($urandom);
         exp_v = ref_add(av, bv, cv);
         run_op(av, bv, cv, s, co, lat, acc, to);
         n_checks++; if (to || {co, s} !== exp_v) begin n_fail++; $display("FAIL b2b_result op %0d got %b/%h want %h", i, co, s, exp_v); end
         if (prev_acc >= 0) begin
            n_checks++; if (acc - prev_acc !== NCHUNK + 2) begin n_fail++; $display("FAIL b2b_spacing op %0d got %0d want %0d", i, acc - prev_acc, NCHUNK + 2); end
         end
         prev_acc = acc;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
